seg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's eight 7-segment tubes. It takes a frame of eight 4-bit hex codes with per-tube decimal-point, blank and blink masks, and emits the scanned `digit1`/`digit2`/`tube_sel` signals. Those signals are the ones the display mux in `top` selects between. Each display producer (`currentTime`, `smoker`, `selfcleaner`) instantiates one driver, so producers only deal in codes, never in segment timing.

---
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Scans eight 7-segment tubes from a shadowed frame of hex codes and dp/blank/blink masks.
// Outputs are registered one cycle behind p/k. Optional blink is enabled by the SEG_BLINK_EN macro.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  dots,
  input  logic [7:0]  blank,
  input  logic [7:0]  blink,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel,
  output logic        frame_start
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] p;
  logic [2:0]    k;
  logic          en_d;
  logic [31:0]   sh_digits;
  logic [7:0]    sh_dots;
  logic [7:0]    sh_blank;
  logic [7:0]    sh_blink;
  logic          slot_end;
  logic          capture;
  logic          suppress;
  logic          visible;
  logic [3:0]    code;
  logic [7:0]    raw;
  logic [7:0]    seg;

  assign slot_end = (p == PW'(SCAN_DIV - 1));
  // Capture at the last cycle of tube 7, or on the first enabled cycle after en was low.
  assign capture  = en && (!en_d || (slot_end && (k == 3'd7)));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      p <= '0;
      k <= '0;
    end else if (slot_end) begin
      p <= '0;
      k <= k + 3'd1;
    end else begin
      p <= p + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_d      <= 1'b0;
      sh_digits <= '0;
      sh_dots   <= '0;
      sh_blank  <= 8'hFF;
      sh_blink  <= '0;
    end else begin
      en_d <= en;
      if (capture) begin
        sh_digits <= digits;
        sh_dots   <= dots;
        sh_blank  <= blank;
        sh_blink  <= blink;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic          phase;

  // Phase also restarts at 0 whenever the display is disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  assign suppress = phase & sh_blink[k];
`else
  logic unused_blink;
  assign unused_blink = ^sh_blink;
  assign suppress     = 1'b0;
`endif

  always_comb begin
    code = sh_digits[{k, 2'b00} +: 4];
    raw  = 8'h00;
    case (code)
      4'h0: raw = 8'hFC;
      4'h1: raw = 8'h60;
      4'h2: raw = 8'hDA;
      4'h3: raw = 8'hF2;
      4'h4: raw = 8'h66;
      4'h5: raw = 8'hB6;
      4'h6: raw = 8'hBE;
      4'h7: raw = 8'hE0;
      4'h8: raw = 8'hFE;
      4'h9: raw = 8'hF6;
      4'hA: raw = 8'hEE;
      4'hB: raw = 8'h3E;
      4'hC: raw = 8'h9C;
      4'hD: raw = 8'h7A;
      4'hE: raw = 8'h9E;
      default: raw = 8'h8E;
    endcase
    seg     = {raw[7:1], sh_dots[k]};
    visible = (p >= PW'(BLANK_CYCLES)) && !sh_blank[k] && !suppress;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit1      <= '0;
      digit2      <= '0;
      tube_sel    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (en && visible) begin
        tube_sel <= 8'd1 << k;
        digit1   <= k[2] ? 8'h00 : seg;
        digit2   <= k[2] ? seg : 8'h00;
      end else begin
        tube_sel <= '0;
        digit1   <= '0;
        digit2   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64.
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dots = '0;
  logic [7:0]  blank = '0;
  logic [7:0]  blink = '0;
  logic [7:0]  digit1, digit2, tube_sel;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  string tag = "reset";
  logic [31:0] expq[$];

  // Reference state: t = enabled cycles since scanning restarted (p = t%8, k = t/8).
  bit          m_en_d = 1'b0;
  int          t = 0;
  int          bc = 0;
  logic [31:0] s_dig = '0;
  logic [7:0]  s_dots = '0;
  logic [7:0]  s_blank = 8'hFF;
  logic [7:0]  s_blink = '0;
  logic [7:0]  segtab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dots(dots), .blank(blank),
    .blink(blink), .digit1(digit1), .digit2(digit2), .tube_sel(tube_sel),
    .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Predicts {frame_start, tube_sel, digit1, digit2} after the coming edge, then advances.
  task automatic model_step();
    logic [31:0] e;
    logic [7:0]  seg;
    int p, k;
    bit cap, vis, ph;
    e = '0;
    if (rst) begin
      m_en_d = 1'b0; t = 0; bc = 0;
      s_dig = '0; s_dots = '0; s_blank = 8'hFF; s_blink = '0;
    end else if (!en) begin
      m_en_d = 1'b0; t = 0; bc = 0;
    end else begin
      p   = t % 8;
      k   = (t / 8) % 8;
      cap = !m_en_d || (t == 63);
      ph  = 1'b0;
`ifdef SEG_BLINK_EN
      ph  = ((bc / 64) % 2) == 1;
`endif
      vis = (p >= 2) && !s_blank[k] && !(ph && s_blink[k]);
      seg = segtab[s_dig[4*k +: 4]] | {7'd0, s_dots[k]};
      if (vis) e[23:0] = {8'd1 << k, (k < 4) ? seg : 8'd0, (k >= 4) ? seg : 8'd0};
      e[24] = cap;
      if (cap) begin
        s_dig = digits; s_dots = dots; s_blank = blank; s_blink = blink;
      end
      t = (t + 1) % 64;
      bc++;
      m_en_d = 1'b1;
    end
    expq.push_back(e);
  endtask

  task automatic step();
    logic [31:0] got, e;
    model_step();
    @(posedge clk);
    #1;
    got = {7'd0, frame_start, tube_sel, digit1, digit2};
    e = expq.pop_front();
    check(tag, got, e);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 200 && t != target; i++) step();
    if (t != target) check("timeout", t, target);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; digits = 32'h76543210; dots = '0; blank = '0; blink = '0;
    repeat (3) step();
    rst = 1'b0;
    tag = "basic";
    repeat (128) step();

    tag = "tear";
    run_until(3*8 + 4);
    digits = 32'hFFFFFFFF;
    repeat (128) step();

    tag = "mask";
    digits = 32'h76543210; blank = 8'h81; dots = 8'h02;
    run_until(0);
    repeat (64) step();

    tag = "enable";
    blank = '0; dots = '0;
    run_until(5*8 + 4);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (70) step();

    tag = "blink";
    blink = 8'h01;
    run_until(0);
    repeat (256) step();

    tag = "midrst";
    run_until(20);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
